// File: rtl/sdrc_multiport_arb.sv
// N-port request arbiter in front of the single sdrc_core app port.
// Per-direction tag FIFOs remember which port owns each outstanding burst.
module sdrc_multiport_arb #(
  parameter int NP        = 4,
  parameter int APP_AW    = 26,
  parameter int APP_DW    = 32,
  parameter int APP_BW    = 4,
  parameter int bl        = 9,
  parameter int TAG_DEPTH = 4,
  localparam int CW       = $clog2(TAG_DEPTH) + 1
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 cfg_arb_mode,
  input  logic [NP-1:0]        p_req,
  input  logic [NP*APP_AW-1:0] p_req_addr,
  input  logic [NP*bl-1:0]     p_req_len,
  input  logic [NP-1:0]        p_req_wr_n,
  output logic [NP-1:0]        p_req_ack,
  input  logic [NP*APP_DW-1:0] p_wr_data,
  input  logic [NP*APP_BW-1:0] p_wr_en_n,
  output logic [NP-1:0]        p_wr_next,
  output logic [NP-1:0]        p_rd_valid,
  output logic [NP-1:0]        p_last_rd,
  output logic [APP_DW-1:0]    p_rd_data,
  output logic                 app_req,
  output logic [APP_AW-1:0]    app_req_addr,
  output logic [bl-1:0]        app_req_len,
  output logic                 app_req_wr_n,
  input  logic                 app_req_ack,
  output logic [APP_DW-1:0]    app_wr_data,
  output logic [APP_BW-1:0]    app_wr_en_n,
  input  logic                 app_wr_next_req,
  input  logic                 app_last_wr,
  input  logic                 app_rd_valid,
  input  logic                 app_last_rd,
  input  logic [APP_DW-1:0]    app_rd_data,
  output logic [CW-1:0]        wr_pend_cnt,
  output logic [CW-1:0]        rd_pend_cnt,
  output logic                 arb_err,
  output logic                 arb_state
);
  // Handshake: a master holds p_req (and its fields) until it sees its one-cycle
  // p_req_ack; app_req is held with stable fields until the core returns app_req_ack.
  localparam int GW = (NP > 1) ? $clog2(NP) : 1;
  localparam int PW = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;
  state_t state, state_nxt;

  logic [GW-1:0] ptr, g, win;
  logic          win_vld, grant_ok, ack;
  logic          wr_push, wr_pop, rd_push, rd_pop;
  logic          wr_full, wr_empty, rd_full, rd_empty;

  logic [GW-1:0] wr_mem [TAG_DEPTH];
  logic [GW-1:0] rd_mem [TAG_DEPTH];
  logic [PW-1:0] wr_wp, wr_rp, rd_wp, rd_rp;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [GW-1:0] wr_head, rd_head;

  // Round-robin searches upward from ptr; fixed priority searches from port 0.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NP; k++) begin
      idx = cfg_arb_mode ? k : int'(ptr) + k;
      if (idx >= NP) idx = idx - NP;
      if (!win_vld && p_req[idx]) begin
        win_vld = 1'b1;
        win     = GW'(idx);
      end
    end
  end

  // Both FIFOs must have room, which covers the winner's own direction too.
  assign grant_ok = win_vld && !wr_full && !rd_full;
  assign ack      = (state == REQ) && app_req_ack;
  assign app_req  = (state == REQ);
  assign arb_state = (state == REQ);

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) state <= IDLE;
    else               state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ok) state_nxt = REQ;
      REQ:     if (app_req_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      g            <= '0;
      ptr          <= '0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b1;
    end else begin
      if (state == IDLE && grant_ok) begin
        g            <= win;
        app_req_addr <= p_req_addr[int'(win)*APP_AW +: APP_AW];
        app_req_len  <= p_req_len[int'(win)*bl +: bl];
        app_req_wr_n <= p_req_wr_n[win];
      end
      if (ack) ptr <= (g == GW'(NP - 1)) ? '0 : g + GW'(1);
    end
  end

  always_comb begin
    p_req_ack = '0;
    if (ack) p_req_ack[g] = 1'b1;
  end

  assign wr_push  = ack && !app_req_wr_n;
  assign rd_push  = ack && app_req_wr_n;
  assign wr_empty = (wr_cnt == '0);
  assign rd_empty = (rd_cnt == '0);
  assign wr_full  = (wr_cnt == CW'(TAG_DEPTH));
  assign rd_full  = (rd_cnt == CW'(TAG_DEPTH));
  assign wr_pop   = app_wr_next_req && app_last_wr && !wr_empty;
  assign rd_pop   = app_rd_valid && app_last_rd && !rd_empty;
  assign wr_head  = wr_mem[wr_rp];
  assign rd_head  = rd_mem[rd_rp];

  // Tag storage needs no reset: the counts alone decide what is valid.
  always_ff @(posedge sdram_clk) begin
    if (wr_push) wr_mem[wr_wp] <= g;
    if (rd_push) rd_mem[rd_wp] <= g;
  end

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      wr_wp   <= '0;
      wr_rp   <= '0;
      wr_cnt  <= '0;
      rd_wp   <= '0;
      rd_rp   <= '0;
      rd_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      if (wr_push) wr_wp <= wr_wp + PW'(1);
      if (wr_pop)  wr_rp <= wr_rp + PW'(1);
      if (wr_push && !wr_pop)      wr_cnt <= wr_cnt + CW'(1);
      else if (wr_pop && !wr_push) wr_cnt <= wr_cnt - CW'(1);
      if (rd_push) rd_wp <= rd_wp + PW'(1);
      if (rd_pop)  rd_rp <= rd_rp + PW'(1);
      if (rd_push && !rd_pop)      rd_cnt <= rd_cnt + CW'(1);
      else if (rd_pop && !rd_push) rd_cnt <= rd_cnt - CW'(1);
      // A data strobe with no owner means the core and the tags disagree.
      if ((app_wr_next_req && wr_empty) || (app_rd_valid && rd_empty)) arb_err <= 1'b1;
    end
  end

  assign wr_pend_cnt = wr_cnt;
  assign rd_pend_cnt = rd_cnt;
  assign p_rd_data   = app_rd_data;

  always_comb begin
    p_wr_next   = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    if (!wr_empty) begin
      p_wr_next[wr_head] = app_wr_next_req;
      app_wr_data        = p_wr_data[int'(wr_head)*APP_DW +: APP_DW];
      app_wr_en_n        = p_wr_en_n[int'(wr_head)*APP_BW +: APP_BW];
    end
  end

  always_comb begin
    p_rd_valid = '0;
    p_last_rd  = '0;
    if (!rd_empty) begin
      p_rd_valid[rd_head] = app_rd_valid;
      p_last_rd[rd_head]  = app_rd_valid && app_last_rd;
    end
  end
endmodule

// File: tb/tb_sdrc_multiport_arb.sv
// Bench for sdrc_multiport_arb: random requests and data phases against a
// queue-based model of grant order and burst ownership.
module tb_sdrc_multiport_arb;
  localparam int NP = 4, AW = 26, DW = 32, BW = 4, BL = 9, TD = 4, CW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_arb_mode;
  logic [NP-1:0]     p_req, p_req_wr_n, p_req_ack, p_wr_next, p_rd_valid, p_last_rd;
  logic [NP*AW-1:0]  p_req_addr;
  logic [NP*BL-1:0]  p_req_len;
  logic [NP*DW-1:0]  p_wr_data;
  logic [NP*BW-1:0]  p_wr_en_n;
  logic [DW-1:0]     p_rd_data, app_wr_data, app_rd_data;
  logic              app_req, app_req_wr_n, app_req_ack;
  logic [AW-1:0]     app_req_addr;
  logic [BL-1:0]     app_req_len;
  logic [BW-1:0]     app_wr_en_n;
  logic              app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd;
  logic [CW-1:0]     wr_pend_cnt, rd_pend_cnt;
  logic              arb_err, arb_state;

  sdrc_multiport_arb #(.NP(NP), .APP_AW(AW), .APP_DW(DW), .APP_BW(BW), .bl(BL), .TAG_DEPTH(TD)) dut (
    .sdram_clk(clk), .sdram_resetn(rst_n), .cfg_arb_mode(cfg_arb_mode),
    .p_req(p_req), .p_req_addr(p_req_addr), .p_req_len(p_req_len), .p_req_wr_n(p_req_wr_n),
    .p_req_ack(p_req_ack), .p_wr_data(p_wr_data), .p_wr_en_n(p_wr_en_n), .p_wr_next(p_wr_next),
    .p_rd_valid(p_rd_valid), .p_last_rd(p_last_rd), .p_rd_data(p_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack), .app_wr_data(app_wr_data),
    .app_wr_en_n(app_wr_en_n), .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd), .app_rd_data(app_rd_data),
    .wr_pend_cnt(wr_pend_cnt), .rd_pend_cnt(rd_pend_cnt), .arb_err(arb_err), .arb_state(arb_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int mdl_wr[$], mdl_rd[$];
  int mdl_ptr;
  logic [AW-1:0] port_addr [NP];
  logic [BL-1:0] port_len  [NP];
  logic          port_wr_n [NP];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_arb_mode = 1'b0; p_req = '0; p_req_wr_n = '1; p_req_addr = '0; p_req_len = '0;
    p_wr_data = '0; p_wr_en_n = '1; app_req_ack = 1'b0; app_wr_next_req = 1'b0;
    app_last_wr = 1'b0; app_rd_valid = 1'b0; app_last_rd = 1'b0; app_rd_data = $urandom;
    tick(); tick();
    rst_n = 1'b1;
    mdl_wr.delete(); mdl_rd.delete(); mdl_ptr = 0;
  endtask

  task automatic set_port(input int i, input logic wn, input logic [AW-1:0] a, input logic [BL-1:0] l);
    p_req_wr_n[i] = wn; p_req_addr[i*AW +: AW] = a; p_req_len[i*BL +: BL] = l;
    port_wr_n[i] = wn; port_addr[i] = a; port_len[i] = l;
  endtask

  function automatic int onehot_idx(input logic [NP-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < NP; i++) if (v[i]) return i;
    return -1;
  endfunction

  // reference arbitration: first requester at or after ptr (RR) or lowest index (fixed)
  function automatic int model_pick(input logic [NP-1:0] m, input bit fixed_mode);
    for (int k = 0; k < NP; k++) begin
      int i;
      i = fixed_mode ? k : (mdl_ptr + k) % NP;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_accept(input int gp);
    mdl_ptr = (gp + 1) % NP;
    if (port_wr_n[gp]) mdl_rd.push_back(gp);
    else               mdl_wr.push_back(gp);
  endfunction

  // driver: wait (bounded) for app_req, ack it, report what was observed
  task automatic grant(output int g, output int waited, output logic [AW-1:0] a,
                       output logic [BL-1:0] l, output logic wn);
    g = -1; waited = 0; a = '0; l = '0; wn = 1'b1;
    while (!app_req && waited < 20) begin tick(); waited++; end
    if (!app_req) begin waited = -1; return; end
    a = app_req_addr; l = app_req_len; wn = app_req_wr_n;
    app_req_ack = 1'b1; #1;
    g = onehot_idx(p_req_ack);
    tick();
    app_req_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #2;
    checks++; if (app_req !== 1'b0) begin failures++; $display("FAIL reset_async_app_req: got %0b want 0", app_req); end
    do_reset();
    checks++; if (app_req !== 1'b0 || app_req_addr !== '0 || app_req_len !== '0 || app_req_wr_n !== 1'b1) begin
      failures++; $display("FAIL reset_app_fields: req=%0b addr=%0h len=%0d wr_n=%0b want 0/0/0/1", app_req, app_req_addr, app_req_len, app_req_wr_n);
    end
    checks++; if ({p_req_ack, p_wr_next, p_rd_valid, p_last_rd} !== '0) begin
      failures++; $display("FAIL reset_port_outs: got %0h want 0", {p_req_ack, p_wr_next, p_rd_valid, p_last_rd});
    end
    checks++; if (app_wr_en_n !== '1 || app_wr_data !== '0) begin
      failures++; $display("FAIL reset_wr_mux: en_n=%0h data=%0h want f/0", app_wr_en_n, app_wr_data);
    end
    checks++; if (wr_pend_cnt !== '0 || rd_pend_cnt !== '0 || arb_err !== 1'b0) begin
      failures++; $display("FAIL reset_counts: wr=%0d rd=%0d err=%0b want 0/0/0", wr_pend_cnt, rd_pend_cnt, arb_err);
    end
  endtask

  task automatic test_single_read();
    int nv, nl;
    logic [NP-1:0] m;
    do_reset();
    set_port(0, 1'b1, 26'h100, 9'd8);
    p_req = 4'b0001; #1;
    checks++; if (app_req !== 1'b0) begin failures++; $display("FAIL rd_pre_grant: app_req=%0b want 0", app_req); end
    tick();
    checks++; if (app_req !== 1'b1 || app_req_addr !== 26'h100 || app_req_len !== 9'd8 || app_req_wr_n !== 1'b1) begin
      failures++; $display("FAIL rd_grant_fields: req=%0b addr=%0h len=%0d wr_n=%0b want 1/100/8/1", app_req, app_req_addr, app_req_len, app_req_wr_n);
    end
    tick(); tick();
    app_req_ack = 1'b1; #1;
    checks++; if (p_req_ack !== 4'b0001) begin failures++; $display("FAIL rd_ack_pulse: got %b want 0001", p_req_ack); end
    tick();
    app_req_ack = 1'b0; p_req = '0;
    model_accept(0);
    checks++; if (app_req !== 1'b0 || rd_pend_cnt !== CW'(mdl_rd.size())) begin
      failures++; $display("FAIL rd_after_ack: req=%0b rd_cnt=%0d want 0/%0d", app_req, rd_pend_cnt, mdl_rd.size());
    end
    nv = 0; nl = 0;
    for (int b = 0; b < 8; b++) begin
      logic [DW-1:0] d;
      d = $urandom;
      app_rd_valid = 1'b1; app_last_rd = (b == 7); app_rd_data = d; #1;
      m = NP'(1) << mdl_rd[0];
      checks++; if (p_rd_valid !== m || p_rd_data !== d) begin
        failures++; $display("FAIL rd_beat%0d: valid=%b data=%0h want %b/%0h", b, p_rd_valid, p_rd_data, m, d);
      end
      if (p_rd_valid[0]) nv++;
      if (p_last_rd[0]) nl++;
      tick();
    end
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    void'(mdl_rd.pop_front());
    checks++; if (nv != 8 || nl != 1 || rd_pend_cnt !== CW'(mdl_rd.size())) begin
      failures++; $display("FAIL rd_burst_totals: valid=%0d last=%0d cnt=%0d want 8/1/%0d", nv, nl, rd_pend_cnt, mdl_rd.size());
    end
  endtask

  task automatic test_round_robin();
    int g, w, exp;
    logic [AW-1:0] a; logic [BL-1:0] l; logic wn;
    logic [NP-1:0] m;
    do_reset();
    for (int i = 0; i < NP; i++)
      set_port(i, (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'($urandom_range(0, 1)), AW'($urandom), BL'($urandom_range(1, 64)));
    p_req = '1;
    for (int n = 0; n < 5; n++) begin
      exp = model_pick('1, 1'b0);
      grant(g, w, a, l, wn);
      checks++; if (g != exp || w != 1 || a !== port_addr[exp] || l !== port_len[exp] || wn !== port_wr_n[exp]) begin
        failures++; $display("FAIL rr_all_grant%0d: port=%0d wait=%0d addr=%0h want port=%0d wait=1 addr=%0h", n, g, w, a, exp, port_addr[exp]);
      end
      model_accept(exp);
    end
    p_req = '0;
    // random request masks, arbitration fixed by the model's pointer
    do_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'($urandom_range(0, 1)), AW'($urandom), BL'($urandom_range(1, 64)));
    for (int n = 0; n < 4; n++) begin
      m = NP'($urandom_range(1, (1 << NP) - 1));
      p_req = m;
      exp = model_pick(m, 1'b0);
      grant(g, w, a, l, wn);
      checks++; if (g != exp || w != 1 || a !== port_addr[exp]) begin
        failures++; $display("FAIL rr_rand_grant%0d: mask=%b port=%0d wait=%0d want port=%0d", n, m, g, w, exp);
      end
      model_accept(exp);
    end
    p_req = '0;
    checks++; if (wr_pend_cnt !== CW'(mdl_wr.size()) || rd_pend_cnt !== CW'(mdl_rd.size())) begin
      failures++; $display("FAIL rr_counts: wr=%0d rd=%0d want %0d/%0d", wr_pend_cnt, rd_pend_cnt, mdl_wr.size(), mdl_rd.size());
    end
  endtask

  task automatic test_fixed_priority();
    int g, w, exp;
    logic [AW-1:0] a; logic [BL-1:0] l; logic wn;
    logic [NP-1:0] m;
    for (int blk = 0; blk < 3; blk++) begin
      do_reset();
      cfg_arb_mode = 1'b1;
      for (int i = 0; i < NP; i++) set_port(i, 1'($urandom_range(0, 1)), AW'($urandom), BL'($urandom_range(1, 64)));
      for (int n = 0; n < 4; n++) begin
        m = (blk == 0) ? '1 : NP'($urandom_range(1, (1 << NP) - 1));
        p_req = m;
        exp = model_pick(m, 1'b1);
        grant(g, w, a, l, wn);
        checks++; if (g != exp || w != 1 || a !== port_addr[exp]) begin
          failures++; $display("FAIL fixed_grant_b%0d_n%0d: mask=%b port=%0d wait=%0d want port=%0d", blk, n, m, g, w, exp);
        end
        model_accept(exp);
      end
      p_req = '0;
    end
  endtask

  task automatic test_interleave();
    int g, w;
    logic [AW-1:0] a; logic [BL-1:0] l; logic wn;
    logic [DW-1:0] ed;
    logic [BW-1:0] ee;
    do_reset();
    set_port(2, 1'b0, AW'($urandom), 9'd4);
    p_req = 4'b0100;
    grant(g, w, a, l, wn);
    p_req = '0;
    checks++; if (g != 2 || wn !== 1'b0) begin failures++; $display("FAIL il_wr_grant: port=%0d wr_n=%0b want 2/0", g, wn); end
    model_accept(2);
    set_port(1, 1'b1, AW'($urandom), 9'd4);
    p_req = 4'b0010;
    grant(g, w, a, l, wn);
    p_req = '0;
    checks++; if (g != 1 || wn !== 1'b1) begin failures++; $display("FAIL il_rd_grant: port=%0d wr_n=%0b want 1/1", g, wn); end
    model_accept(1);
    // write and read bursts run concurrently; each must land only on its owner
    for (int b = 0; b < 4; b++) begin
      p_wr_data = {$urandom, $urandom, $urandom, $urandom};
      p_wr_en_n = NP*BW'($urandom);
      ed = p_wr_data[mdl_wr[0]*DW +: DW];
      ee = p_wr_en_n[mdl_wr[0]*BW +: BW];
      app_wr_next_req = 1'b1; app_last_wr = (b == 3);
      app_rd_valid = 1'b1; app_last_rd = (b == 3); app_rd_data = $urandom; #1;
      checks++; if (p_wr_next !== NP'(1) << mdl_wr[0] || app_wr_data !== ed || app_wr_en_n !== ee) begin
        failures++; $display("FAIL il_wr_beat%0d: next=%b data=%0h en_n=%0h want %b/%0h/%0h", b, p_wr_next, app_wr_data, app_wr_en_n, NP'(1) << mdl_wr[0], ed, ee);
      end
      checks++; if (p_rd_valid !== NP'(1) << mdl_rd[0] || p_last_rd !== ((b == 3) ? NP'(1) << mdl_rd[0] : NP'(0))) begin
        failures++; $display("FAIL il_rd_beat%0d: valid=%b last=%b want owner %0d", b, p_rd_valid, p_last_rd, mdl_rd[0]);
      end
      tick();
    end
    app_wr_next_req = 1'b0; app_last_wr = 1'b0; app_rd_valid = 1'b0; app_last_rd = 1'b0;
    void'(mdl_wr.pop_front()); void'(mdl_rd.pop_front());
    #1;
    checks++; if (wr_pend_cnt !== '0 || rd_pend_cnt !== '0 || app_wr_en_n !== '1 || app_wr_data !== '0 || arb_err !== 1'b0) begin
      failures++; $display("FAIL il_drained: wr=%0d rd=%0d en_n=%0h data=%0h err=%0b want 0/0/f/0/0", wr_pend_cnt, rd_pend_cnt, app_wr_en_n, app_wr_data, arb_err);
    end
  endtask

  task automatic test_full();
    int g, w, p5, pw, saw;
    logic [AW-1:0] a; logic [BL-1:0] l; logic wn;
    do_reset();
    for (int n = 0; n < TD; n++) begin
      int p;
      p = $urandom_range(0, NP - 1);
      set_port(p, 1'b1, AW'($urandom), BL'($urandom_range(1, 16)));
      p_req = NP'(1) << p;
      grant(g, w, a, l, wn);
      p_req = '0;
      checks++; if (g != p) begin failures++; $display("FAIL full_fill%0d: port=%0d want %0d", n, g, p); end
      model_accept(p);
    end
    checks++; if (rd_pend_cnt !== CW'(TD)) begin failures++; $display("FAIL full_count: got %0d want %0d", rd_pend_cnt, TD); end
    p5 = $urandom_range(0, NP - 1);
    set_port(p5, 1'b1, AW'($urandom), 9'd2);
    p_req = NP'(1) << p5;
    saw = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (app_req) saw = 1; end
    checks++; if (saw != 0) begin failures++; $display("FAIL full_blocked: app_req seen=%0d want 0", saw); end
    app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    checks++; if (p_rd_valid !== NP'(1) << mdl_rd[0]) begin failures++; $display("FAIL full_pop_route: got %b want owner %0d", p_rd_valid, mdl_rd[0]); end
    tick();
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    void'(mdl_rd.pop_front());
    checks++; if (rd_pend_cnt !== CW'(mdl_rd.size())) begin failures++; $display("FAIL full_after_pop: got %0d want %0d", rd_pend_cnt, mdl_rd.size()); end
    // the stalled read now goes through, acked in the same cycle as a last read beat
    w = 0;
    while (!app_req && w < 20) begin tick(); w++; end
    app_req_ack = 1'b1; app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    checks++; if (p_req_ack !== NP'(1) << p5 || p_rd_valid !== NP'(1) << mdl_rd[0]) begin
      failures++; $display("FAIL full_push_pop_rd: ack=%b valid=%b want port %0d owner %0d", p_req_ack, p_rd_valid, p5, mdl_rd[0]);
    end
    tick();
    app_req_ack = 1'b0; app_rd_valid = 1'b0; app_last_rd = 1'b0; p_req = '0;
    void'(mdl_rd.pop_front()); model_accept(p5);
    checks++; if (rd_pend_cnt !== CW'(mdl_rd.size())) begin failures++; $display("FAIL full_same_cnt: got %0d want %0d", rd_pend_cnt, mdl_rd.size()); end
    pw = $urandom_range(0, NP - 1);
    set_port(pw, 1'b0, AW'($urandom), 9'd1);
    p_req = NP'(1) << pw;
    w = 0;
    while (!app_req && w < 20) begin tick(); w++; end
    app_req_ack = 1'b1; app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    checks++; if (p_req_ack !== NP'(1) << pw) begin failures++; $display("FAIL full_wr_ack: got %b want port %0d", p_req_ack, pw); end
    tick();
    app_req_ack = 1'b0; app_rd_valid = 1'b0; app_last_rd = 1'b0; p_req = '0;
    void'(mdl_rd.pop_front()); model_accept(pw);
    checks++; if (wr_pend_cnt !== CW'(mdl_wr.size()) || rd_pend_cnt !== CW'(mdl_rd.size())) begin
      failures++; $display("FAIL full_wr_with_pop: wr=%0d rd=%0d want %0d/%0d", wr_pend_cnt, rd_pend_cnt, mdl_wr.size(), mdl_rd.size());
    end
  endtask

  task automatic test_error();
    do_reset();
    app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    checks++; if (p_rd_valid !== '0 || p_last_rd !== '0) begin failures++; $display("FAIL err_rd_route: valid=%b last=%b want 0/0", p_rd_valid, p_last_rd); end
    tick();
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
    checks++; if (arb_err !== 1'b1 || rd_pend_cnt !== '0) begin failures++; $display("FAIL err_rd_set: err=%0b cnt=%0d want 1/0", arb_err, rd_pend_cnt); end
    tick(); tick(); tick();
    checks++; if (arb_err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0b want 1", arb_err); end
    do_reset();
    app_wr_next_req = 1'b1; app_last_wr = 1'b1; #1;
    checks++; if (p_wr_next !== '0) begin failures++; $display("FAIL err_wr_route: got %b want 0", p_wr_next); end
    tick();
    app_wr_next_req = 1'b0; app_last_wr = 1'b0;
    checks++; if (arb_err !== 1'b1 || wr_pend_cnt !== '0) begin failures++; $display("FAIL err_wr_set: err=%0b cnt=%0d want 1/0", arb_err, wr_pend_cnt); end
  endtask

  task automatic test_reset_mid();
    int g, w;
    logic [AW-1:0] a; logic [BL-1:0] l; logic wn;
    do_reset();
    set_port(0, 1'b1, AW'($urandom), 9'd4);
    p_req = 4'b0001;
    grant(g, w, a, l, wn);
    p_req = '0;
    set_port(3, 1'b0, AW'($urandom), 9'd4);
    p_req = 4'b1000;
    w = 0;
    while (!app_req && w < 20) begin tick(); w++; end
    checks++; if (app_req !== 1'b1 || rd_pend_cnt !== CW'(1)) begin failures++; $display("FAIL mid_setup: req=%0b rd=%0d want 1/1", app_req, rd_pend_cnt); end
    #2 rst_n = 1'b0; #1;
    checks++; if (app_req !== 1'b0 || rd_pend_cnt !== '0 || wr_pend_cnt !== '0 || app_req_wr_n !== 1'b1) begin
      failures++; $display("FAIL mid_async_clear: req=%0b rd=%0d wr=%0d wr_n=%0b want 0/0/0/1", app_req, rd_pend_cnt, wr_pend_cnt, app_req_wr_n);
    end
    p_req = '0;
    tick(); rst_n = 1'b1; tick();
    app_rd_valid = 1'b1; app_last_rd = 1'b1; #1;
    checks++; if (p_rd_valid !== '0) begin failures++; $display("FAIL mid_tags_dropped: got %b want 0", p_rd_valid); end
    tick();
    app_rd_valid = 1'b0; app_last_rd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_interleave();
    test_full();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
